// File: rtl/pong_game_ctrl.sv
// Pong game controller: frame-tick generation, serve/play/point/over FSM,
// ball and paddle motion with wall and paddle collisions, scoring, and a
// combinational pixel colour generator for the VGA timing block.
module pong_game_ctrl #(
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_STEP  = 8,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] curr_x,
  input  logic [10:0] curr_y,
  input  logic        vsync,
  input  logic        up_l,
  input  logic        dn_l,
  input  logic        up_r,
  input  logic        dn_r,
  input  logic        start,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [10:0] BALL_SZ   = 11'd16;
  localparam logic [10:0] BALL_X0   = 11'd632;
  localparam logic [10:0] BALL_Y0   = 11'd392;
  localparam logic [10:0] PAD_Y0    = 11'd352;
  localparam logic [10:0] PAD_MAX   = 11'(800 - PADDLE_H);
  localparam logic [10:0] PAD_H     = 11'(PADDLE_H);
  localparam logic [10:0] PAD_STEP  = 11'(PADDLE_STEP);
  localparam logic [11:0] SPD       = 12'(BALL_SPEED);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
  localparam logic [7:0]  SRV_LAST  = 8'(SERVE_FRAMES - 1);

  // dx/dy: 1 = moving toward larger coordinate, 0 = toward smaller
  state_t      r_state, w_state_n;
  logic        r_vs_d1, r_vs_d2;
  logic [10:0] r_ball_x, r_ball_y, w_ball_x_n, w_ball_y_n;
  logic        r_dx, r_dy, w_dx_n, w_dy_n;
  logic [10:0] r_pad_l, r_pad_r, w_pad_l_n, w_pad_r_n;
  logic [3:0]  r_score_l, r_score_r, w_score_l_n, w_score_r_n, w_new_score;
  logic [7:0]  r_cnt, w_cnt_n;
  logic        r_scorer, w_scorer_n;   // 1 = left player scored

  logic        w_tick;
  logic [11:0] w_cx, w_cy;
  logic        w_cx_low, w_cx_high, w_cx_le_l, w_cx_ge_r;
  logic        w_cy_low, w_cy_high;
  logic        w_ovl_l, w_ovl_r, w_bounce_l, w_bounce_r;
  logic        w_in_ball, w_in_pad, w_in_line;

  // Paddle step with clamping; both or neither button holds position
  function automatic logic [10:0] f_pad_move(input logic [10:0] y, input logic up, input logic dn);
    if (up && !dn)      return (y < PAD_STEP) ? 11'd0 : (y - PAD_STEP);
    else if (dn && !up) return ((y + PAD_STEP) > PAD_MAX) ? PAD_MAX : (y + PAD_STEP);
    else                return y;
  endfunction

  // Score increment saturating at the winning score
  function automatic logic [3:0] f_score_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : (s + 4'd1);
  endfunction

  assign w_tick = r_vs_d1 & ~r_vs_d2;

  // Candidate position computed in 12 bits so a step past zero is detectable
  assign w_cx = r_dx ? ({1'b0, r_ball_x} + SPD) : ({1'b0, r_ball_x} - SPD);
  assign w_cy = r_dy ? ({1'b0, r_ball_y} + SPD) : ({1'b0, r_ball_y} - SPD);
  assign w_cx_low  = w_cx[11] || (w_cx == 12'd0);
  assign w_cx_high = !w_cx[11] && (w_cx >= 12'd1264);
  assign w_cx_le_l = w_cx[11] || (w_cx <= 12'd48);
  assign w_cx_ge_r = !w_cx[11] && (w_cx >= 12'd1216);
  assign w_cy_low  = w_cy[11] || (w_cy == 12'd0);
  assign w_cy_high = !w_cy[11] && (w_cy >= 12'd784);

  assign w_ovl_l = ((r_ball_y + BALL_SZ) > r_pad_l) && (r_ball_y < (r_pad_l + PAD_H));
  assign w_ovl_r = ((r_ball_y + BALL_SZ) > r_pad_r) && (r_ball_y < (r_pad_r + PAD_H));
  assign w_bounce_l = !r_dx && w_cx_le_l && (r_ball_x >= 11'd48)   && w_ovl_l;
  assign w_bounce_r =  r_dx && w_cx_ge_r && (r_ball_x <= 11'd1216) && w_ovl_r;

  assign w_new_score = r_scorer ? f_score_inc(r_score_l) : f_score_inc(r_score_r);

  // Vsync edge detector on registered copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
    end else begin
      r_vs_d1 <= vsync;
      r_vs_d2 <= r_vs_d1;
    end
  end

  // Game state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ball_x  <= BALL_X0;
      r_ball_y  <= BALL_Y0;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_pad_l   <= PAD_Y0;
      r_pad_r   <= PAD_Y0;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
      r_cnt     <= 8'd0;
      r_scorer  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ball_x  <= w_ball_x_n;
      r_ball_y  <= w_ball_y_n;
      r_dx      <= w_dx_n;
      r_dy      <= w_dy_n;
      r_pad_l   <= w_pad_l_n;
      r_pad_r   <= w_pad_r_n;
      r_score_l <= w_score_l_n;
      r_score_r <= w_score_r_n;
      r_cnt     <= w_cnt_n;
      r_scorer  <= w_scorer_n;
    end
  end

  // Next-state and game update logic
  always_comb begin
    w_state_n   = r_state;
    w_ball_x_n  = r_ball_x;
    w_ball_y_n  = r_ball_y;
    w_dx_n      = r_dx;
    w_dy_n      = r_dy;
    w_pad_l_n   = r_pad_l;
    w_pad_r_n   = r_pad_r;
    w_score_l_n = r_score_l;
    w_score_r_n = r_score_r;
    w_cnt_n     = r_cnt;
    w_scorer_n  = r_scorer;
    case (r_state)
      ST_IDLE: begin
        w_ball_x_n  = BALL_X0;
        w_ball_y_n  = BALL_Y0;
        w_score_l_n = 4'd0;
        w_score_r_n = 4'd0;
        if (start) begin
          w_state_n = ST_SERVE;
          w_dx_n    = 1'b1;
          w_cnt_n   = 8'd0;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_SERVE: begin
        w_ball_x_n = BALL_X0;
        w_ball_y_n = BALL_Y0;
        if (w_tick) begin
          w_pad_l_n = f_pad_move(r_pad_l, up_l, dn_l);
          w_pad_r_n = f_pad_move(r_pad_r, up_r, dn_r);
          if (r_cnt == SRV_LAST) begin
            w_state_n = ST_PLAY;
          end else begin
            w_cnt_n = r_cnt + 8'd1;
          end
        end else begin
          w_state_n = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (w_tick) begin
          w_pad_l_n = f_pad_move(r_pad_l, up_l, dn_l);
          w_pad_r_n = f_pad_move(r_pad_r, up_r, dn_r);
          if (w_cy_low) begin
            w_ball_y_n = 11'd0;
            w_dy_n     = 1'b1;
          end else if (w_cy_high) begin
            w_ball_y_n = 11'd784;
            w_dy_n     = 1'b0;
          end else begin
            w_ball_y_n = w_cy[10:0];
          end
          if (w_bounce_l) begin
            w_ball_x_n = 11'd48;
            w_dx_n     = 1'b1;
          end else if (w_bounce_r) begin
            w_ball_x_n = 11'd1216;
            w_dx_n     = 1'b0;
          end else if (w_cx_low) begin
            w_scorer_n = 1'b0;
            w_state_n  = ST_POINT;
          end else if (w_cx_high) begin
            w_scorer_n = 1'b1;
            w_state_n  = ST_POINT;
          end else begin
            w_ball_x_n = w_cx[10:0];
          end
        end else begin
          w_state_n = ST_PLAY;
        end
      end
      ST_POINT: begin
        // Single-cycle state: score, then re-serve toward the conceding side
        w_ball_x_n = BALL_X0;
        w_ball_y_n = BALL_Y0;
        w_cnt_n    = 8'd0;
        w_dx_n     = r_scorer;
        if (r_scorer) begin
          w_score_l_n = w_new_score;
        end else begin
          w_score_r_n = w_new_score;
        end
        if (w_new_score == WIN) begin
          w_state_n = ST_OVER;
        end else begin
          w_state_n = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (start) begin
          w_score_l_n = 4'd0;
          w_score_r_n = 4'd0;
          w_ball_x_n  = BALL_X0;
          w_ball_y_n  = BALL_Y0;
          w_dx_n      = 1'b1;
          w_cnt_n     = 8'd0;
          w_state_n   = ST_SERVE;
        end else begin
          w_state_n = ST_OVER;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign w_in_ball = (curr_x >= r_ball_x) && (curr_x < (r_ball_x + BALL_SZ)) &&
                     (curr_y >= r_ball_y) && (curr_y < (r_ball_y + BALL_SZ));
  assign w_in_pad  = (curr_x >= 11'd32 && curr_x <= 11'd47 &&
                      curr_y >= r_pad_l && curr_y < (r_pad_l + PAD_H)) ||
                     (curr_x >= 11'd1232 && curr_x <= 11'd1247 &&
                      curr_y >= r_pad_r && curr_y < (r_pad_r + PAD_H));
  assign w_in_line = (curr_x >= 11'd638) && (curr_x <= 11'd641) && !curr_y[4];

  // Pixel colour with object priority: ball, paddles, centre line, background
  always_comb begin
    {r, g, b} = 12'h000;
    if (w_in_ball || w_in_pad) begin
      {r, g, b} = 12'hFFF;
    end else if (w_in_line) begin
      {r, g, b} = 12'h888;
    end else if (r_state == ST_OVER) begin
      {r, g, b} = 12'h400;
    end else begin
      {r, g, b} = 12'h000;
    end
  end

  assign score_l = r_score_l;
  assign score_r = r_score_r;
  assign state   = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: reset-pixel vector table, hand sequences for
// serve timing, paddle clamping and mid-play reset, then randomized play
// checked tick by tick against a plain-arithmetic game model.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] curr_x = 11'd0, curr_y = 11'd0;
  logic        vsync = 1'b0;
  logic        up_l = 1'b0, dn_l = 1'b0, up_r = 1'b0, dn_r = 1'b0, start = 1'b0;
  logic [3:0]  r, g, b, score_l, score_r;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .curr_x(curr_x), .curr_y(curr_y), .vsync(vsync),
    .up_l(up_l), .dn_l(dn_l), .up_r(up_r), .dn_r(dn_r), .start(start),
    .r(r), .g(g), .b(b), .score_l(score_l), .score_r(score_r), .state(state)
  );

  always #5 clk = ~clk;

  // Model of the game (0 idle, 1 serve, 2 play, 4 over; positions as ints)
  int ms, mbx, mby, mdx, mdy, mpl, mpr, msl, msr, mticks;

  typedef struct {
    int x;
    int y;
    int rgb;
  } pix_vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mbx = 632; mby = 392; mdx = 1; mdy = 1;
    mpl = 352; mpr = 352; msl = 0; msr = 0; mticks = 0;
  endtask

  task automatic model_start();
    if (ms == 0 || ms == 4) begin
      ms = 1; msl = 0; msr = 0; mdx = 1; mticks = 0; mbx = 632; mby = 392;
    end
  endtask

  function automatic int pad_step(input int y, input logic up, input logic dn);
    if (up && !dn) return (y - 8 < 0) ? 0 : y - 8;
    if (dn && !up) return (y + 8 > 704) ? 704 : y + 8;
    return y;
  endfunction

  task automatic model_tick(input logic ul, input logic dl, input logic ur, input logic dr,
                            output int point);
    int nx, ny, scorer;
    bit lb, rb;
    point = 0;
    if (ms == 1) begin
      mticks++;
      if (mticks == 60) ms = 2;
      mpl = pad_step(mpl, ul, dl);
      mpr = pad_step(mpr, ur, dr);
    end else if (ms == 2) begin
      ny = mby + mdy * 4;
      if (ny <= 0) begin ny = 0; mdy = 1; end
      else if (ny >= 784) begin ny = 784; mdy = -1; end
      nx = mbx + mdx * 4;
      lb = (mdx < 0) && (nx <= 48) && (mbx >= 48) && (mby + 16 > mpl) && (mby < mpl + 96);
      rb = (mdx > 0) && (nx >= 1216) && (mbx <= 1216) && (mby + 16 > mpr) && (mby < mpr + 96);
      scorer = 0;
      if (lb) begin nx = 48; mdx = 1; end
      else if (rb) begin nx = 1216; mdx = -1; end
      else if (nx <= 0) scorer = 2;
      else if (nx >= 1264) scorer = 1;
      mbx = nx; mby = ny;
      if (scorer != 0) begin
        point = 1;
        if (scorer == 1) msl = (msl + 1 > 9) ? 9 : msl + 1;
        else             msr = (msr + 1 > 9) ? 9 : msr + 1;
        mdx = (scorer == 1) ? 1 : -1;
        mbx = 632; mby = 392; mticks = 0;
        ms = (msl == 9 || msr == 9) ? 4 : 1;
      end
      mpl = pad_step(mpl, ul, dl);
      mpr = pad_step(mpr, ur, dr);
    end
  endtask

  function automatic int model_pix(input int px, input int py);
    if (px >= mbx && px < mbx + 16 && py >= mby && py < mby + 16) return 'hFFF;
    if (px >= 32 && px <= 47 && py >= mpl && py < mpl + 96) return 'hFFF;
    if (px >= 1232 && px <= 1247 && py >= mpr && py < mpr + 96) return 'hFFF;
    if (px >= 638 && px <= 641 && ((py / 16) % 2) == 0) return 'h888;
    return (ms == 4) ? 'h400 : 'h000;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_state"}, int'(state), ms);
    chk({tag, "_score_l"}, int'(score_l), msl);
    chk({tag, "_score_r"}, int'(score_r), msr);
    chk({tag, "_ball_x"}, int'(dut.r_ball_x), mbx);
    chk({tag, "_ball_y"}, int'(dut.r_ball_y), mby);
    chk({tag, "_dx"}, int'(dut.r_dx), (mdx > 0) ? 1 : 0);
    chk({tag, "_dy"}, int'(dut.r_dy), (mdy > 0) ? 1 : 0);
    chk({tag, "_pad_l"}, int'(dut.r_pad_l), mpl);
    chk({tag, "_pad_r"}, int'(dut.r_pad_r), mpr);
  endtask

  task automatic pix_check(input string tag, input int px, input int py);
    curr_x = 11'(px); curr_y = 11'(py);
    #1;
    chk(tag, int'({r, g, b}), model_pix(px, py));
  endtask

  // One frame: vsync pulse of two clocks, count clocks spent in POINT
  task automatic do_tick(input logic ul, input logic dl, input logic ur, input logic dr,
                         output int pts);
    @(negedge clk);
    up_l = ul; dn_l = dl; up_r = ur; dn_r = dr;
    vsync = 1'b1;
    pts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (state == 3'd3) pts++;
      if (c == 1) vsync = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  task automatic tick_and_check(input logic ul, input logic dl, input logic ur, input logic dr,
                                input string tag);
    int pts, mp;
    do_tick(ul, dl, ur, dr, pts);
    model_tick(ul, dl, ur, dr, mp);
    chk({tag, "_point_clks"}, pts, mp);
    compare_all(tag);
  endtask

  pix_vec_t vecs[12];

  initial begin
    vecs[0]  = '{640, 400, 'hFFF};   // ball over centre line
    vecs[1]  = '{632, 392, 'hFFF};   // ball top-left
    vecs[2]  = '{647, 407, 'hFFF};   // ball bottom-right
    vecs[3]  = '{648, 407, 'h000};   // just right of ball
    vecs[4]  = '{631, 392, 'h000};   // just left of ball
    vecs[5]  = '{40, 400, 'hFFF};    // left paddle
    vecs[6]  = '{40, 351, 'h000};    // above left paddle
    vecs[7]  = '{47, 447, 'hFFF};    // left paddle last row
    vecs[8]  = '{40, 448, 'h000};    // below left paddle
    vecs[9]  = '{1240, 352, 'hFFF};  // right paddle top row
    vecs[10] = '{640, 0, 'h888};     // centre line dash
    vecs[11] = '{640, 16, 'h000};    // centre line gap

    model_reset();
    #12;
    // Reset-state outputs and pixel table while held in reset
    chk("rst_state", int'(state), 0);
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    for (int i = 0; i < 12; i++) begin
      curr_x = 11'(vecs[i].x); curr_y = 11'(vecs[i].y);
      #1;
      chk($sformatf("rst_pix%0d", i), int'({r, g, b}), vecs[i].rgb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    compare_all("idle");

    // Serve: 60 ticks to PLAY; left up held 50 ticks, right both buttons
    press_start();
    chk("start_state", int'(state), 1);
    for (int t = 1; t <= 60; t++) begin
      tick_and_check(t <= 50, 1'b0, 1'b1, 1'b1, "serve");
      if (t == 43) chk("pad_l_t43", int'(dut.r_pad_l), 8);
      if (t == 44) chk("pad_l_t44", int'(dut.r_pad_l), 0);
      if (t == 50) chk("pad_l_t50", int'(dut.r_pad_l), 0);
      if (t == 59) chk("serve_t59_state", int'(state), 1);
    end
    chk("serve_t60_state", int'(state), 2);
    chk("pad_r_both", int'(dut.r_pad_r), 352);
    tick_and_check(1'b0, 1'b0, 1'b0, 1'b0, "play1");
    chk("play1_x", int'(dut.r_ball_x), 636);
    chk("play1_y", int'(dut.r_ball_y), 396);
    for (int t = 0; t < 5; t++) tick_and_check(1'b0, 1'b1, 1'b1, 1'b0, "play");
    pix_check("play_pix_ball", mbx + 8, mby + 8);

    // Asynchronous reset between clock edges during play
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized game to OVER: left paddle random, right paddle evades the ball
    press_start();
    for (int t = 0; t < 6000 && ms != 4; t++) begin
      logic ul, dl, ur, dr;
      int sel;
      {ul, dl} = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      if (sel == 0) {ur, dr} = 2'($urandom_range(0, 3));
      else if (mby < 400) {ur, dr} = 2'b01;
      else {ur, dr} = 2'b10;
      tick_and_check(ul, dl, ur, dr, "rand");
      if ($urandom_range(0, 1) == 1)
        pix_check("rand_pix_ball", mbx + $urandom_range(0, 15), mby + $urandom_range(0, 15));
      else
        pix_check("rand_pix_any", $urandom_range(0, 1279), $urandom_range(0, 799));
    end
    chk("reach_over", int'(state), 4);
    pix_check("over_bg", 100, 20);
    tick_and_check(1'b1, 1'b0, 1'b0, 1'b1, "over_hold");
    press_start();
    compare_all("restart");
    chk("restart_state", int'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
